// File: rtl/fmlarb.sv
// Four-master round-robin arbiter for a 4-beat burst FML slave.
// The grant is held for the whole burst so that write beats 1-3 come from the same master.
module fmlarb #(
    parameter int fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,

    input  logic [fml_depth-1:0] m0_adr,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    output logic                 m0_ack,
    input  logic [7:0]           m0_sel,
    input  logic [63:0]          m0_do,
    output logic [63:0]          m0_di,

    input  logic [fml_depth-1:0] m1_adr,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    output logic                 m1_ack,
    input  logic [7:0]           m1_sel,
    input  logic [63:0]          m1_do,
    output logic [63:0]          m1_di,

    input  logic [fml_depth-1:0] m2_adr,
    input  logic                 m2_stb,
    input  logic                 m2_we,
    output logic                 m2_ack,
    input  logic [7:0]           m2_sel,
    input  logic [63:0]          m2_do,
    output logic [63:0]          m2_di,

    input  logic [fml_depth-1:0] m3_adr,
    input  logic                 m3_stb,
    input  logic                 m3_we,
    output logic                 m3_ack,
    input  logic [7:0]           m3_sel,
    input  logic [63:0]          m3_do,
    output logic [63:0]          m3_di,

    output logic [fml_depth-1:0] s_adr,
    output logic                 s_stb,
    output logic                 s_we,
    input  logic                 s_ack,
    output logic [7:0]           s_sel,
    output logic [63:0]          s_do,
    input  logic [63:0]          s_di
);

    // state | meaning
    // ARB   | grant presented to slave, waiting for s_ack or re-arbitrating
    // DATA1 | burst beat 1, grant locked
    // DATA2 | burst beat 2, grant locked
    // DATA3 | burst beat 3, next grant chosen for a bubble-free ARB
    typedef enum logic [1:0] {ARB, DATA1, DATA2, DATA3} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_grant;
    logic [1:0] w_grant_nxt;
    logic [1:0] w_rr;
    logic [3:0] w_req;

    assign w_req = {m3_stb, m2_stb, m1_stb, m0_stb};

    always_comb begin
        s_adr = m0_adr;
        s_we  = m0_we;
        s_sel = m0_sel;
        s_do  = m0_do;
        case (r_grant)
            2'd1: begin s_adr = m1_adr; s_we = m1_we; s_sel = m1_sel; s_do = m1_do; end
            2'd2: begin s_adr = m2_adr; s_we = m2_we; s_sel = m2_sel; s_do = m2_do; end
            2'd3: begin s_adr = m3_adr; s_we = m3_we; s_sel = m3_sel; s_do = m3_do; end
            default: ;
        endcase
    end

    assign s_stb  = (r_state == ARB) && w_req[r_grant] && !sys_rst;
    assign m0_ack = s_stb && s_ack && (r_grant == 2'd0);
    assign m1_ack = s_stb && s_ack && (r_grant == 2'd1);
    assign m2_ack = s_stb && s_ack && (r_grant == 2'd2);
    assign m3_ack = s_stb && s_ack && (r_grant == 2'd3);

    assign m0_di = s_di;
    assign m1_di = s_di;
    assign m2_di = s_di;
    assign m3_di = s_di;

    // Falling through to the current grant also covers the DATA3 case where
    // the current master is the last candidate in the rotation.
    always_comb begin
        w_rr = r_grant;
        if (w_req[r_grant + 2'd1])
            w_rr = r_grant + 2'd1;
        else if (w_req[r_grant + 2'd2])
            w_rr = r_grant + 2'd2;
        else if (w_req[r_grant + 2'd3])
            w_rr = r_grant + 2'd3;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            ARB: begin
                if (s_stb && s_ack)
                    w_state_nxt = DATA1;
                else if (!w_req[r_grant])
                    w_grant_nxt = w_rr;
            end
            DATA1: w_state_nxt = DATA2;
            DATA2: w_state_nxt = DATA3;
            DATA3: begin
                w_state_nxt = ARB;
                w_grant_nxt = w_rr;
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ARB;
            r_grant <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

endmodule

// File: tb/tb_fmlarb.sv
// Randomized bench for fmlarb against a burst/grant reference model.
// Model tracks the grant and remaining data beats of the current burst.
module tb_fmlarb;

    localparam int AW = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] adr  [4];
    logic [3:0]    stb;
    logic [3:0]    we;
    logic [7:0]    sel  [4];
    logic [63:0]   dout [4];
    logic          s_ack;
    logic [63:0]   s_di;

    wire  [3:0]    ack;
    wire  [63:0]   di0, di1, di2, di3;
    wire  [AW-1:0] s_adr;
    wire           s_stb, s_we;
    wire  [7:0]    s_sel;
    wire  [63:0]   s_do;

    int n_checks = 0;
    int n_errors = 0;

    int m_grant;
    int m_beats;

    bit rr_mode = 1'b0;
    int rr_last = -1;
    int rr_gap  = 0;

    always #5 clk = ~clk;

    fmlarb #(.fml_depth(AW)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .m0_adr(adr[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_ack(ack[0]),
        .m0_sel(sel[0]), .m0_do(dout[0]), .m0_di(di0),
        .m1_adr(adr[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_ack(ack[1]),
        .m1_sel(sel[1]), .m1_do(dout[1]), .m1_di(di1),
        .m2_adr(adr[2]), .m2_stb(stb[2]), .m2_we(we[2]), .m2_ack(ack[2]),
        .m2_sel(sel[2]), .m2_do(dout[2]), .m2_di(di2),
        .m3_adr(adr[3]), .m3_stb(stb[3]), .m3_we(we[3]), .m3_ack(ack[3]),
        .m3_sel(sel[3]), .m3_do(dout[3]), .m3_di(di3),
        .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_ack(s_ack),
        .s_sel(s_sel), .s_do(s_do), .s_di(s_di)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester scanning n positions after g (n=4 wraps back to g itself).
    function automatic int pick(input int g, input int n, input logic [3:0] req);
        for (int k = 1; k <= n; k++)
            if (req[(g + k) % 4]) return (g + k) % 4;
        return g;
    endfunction

    task automatic check_and_step();
        logic       e_stb;
        logic [3:0] e_ack;
        int         idx;
        e_stb = !rst && (m_beats == 0) && stb[m_grant];
        e_ack = (e_stb && s_ack) ? (4'b0001 << m_grant) : 4'b0000;
        chk("s_stb", {63'd0, s_stb}, {63'd0, e_stb});
        chk("ack",   {60'd0, ack},   {60'd0, e_ack});
        chk("s_adr", {38'd0, s_adr}, {38'd0, adr[m_grant]});
        chk("s_we",  {63'd0, s_we},  {63'd0, we[m_grant]});
        chk("s_sel", {56'd0, s_sel}, {56'd0, sel[m_grant]});
        chk("s_do",  s_do, dout[m_grant]);
        chk("m0_di", di0, s_di);
        chk("m1_di", di1, s_di);
        chk("m2_di", di2, s_di);
        chk("m3_di", di3, s_di);

        if (rr_mode) begin
            rr_gap++;
            idx = -1;
            for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
            if (idx >= 0) begin
                if (rr_last >= 0) begin
                    chk("rr_order", 64'(idx), 64'((rr_last + 1) % 4));
                    chk("rr_gap", 64'(rr_gap), 64'd4);
                end
                rr_last = idx;
                rr_gap  = 0;
            end
        end

        if (rst) begin
            m_grant = 0;
            m_beats = 0;
        end else if (m_beats == 0) begin
            if (e_stb && s_ack)
                m_beats = 3;
            else if (!stb[m_grant])
                m_grant = pick(m_grant, 3, stb);
        end else begin
            if (m_beats == 1) m_grant = pick(m_grant, 4, stb);
            m_beats--;
        end
    endtask

    task automatic run_phase(input int ncyc, input int p_stb, input int p_ack, input int p_rst);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(99) < p_rst);
            for (int i = 0; i < 4; i++) begin
                stb[i]  = ($urandom_range(99) < p_stb);
                we[i]   = $urandom_range(1);
                adr[i]  = AW'($urandom);
                sel[i]  = 8'($urandom);
                dout[i] = {$urandom, $urandom};
            end
            s_ack = ($urandom_range(99) < p_ack);
            s_di  = {$urandom, $urandom};
            #3;
            check_and_step();
        end
    endtask

    initial begin
        rst   = 1'b1;
        stb   = 4'd0;
        we    = 4'd0;
        s_ack = 1'b0;
        s_di  = 64'd0;
        for (int i = 0; i < 4; i++) begin
            adr[i]  = '0;
            sel[i]  = '0;
            dout[i] = '0;
        end
        repeat (2) @(posedge clk);
        m_grant = 0;
        m_beats = 0;
        run_phase(4, 100, 100, 100);
        run_phase(400, 30, 50, 0);
        run_phase(400, 70, 60, 2);
        rr_mode = 1'b1;
        run_phase(200, 100, 100, 0);
        rr_mode = 1'b0;
        run_phase(300, 10, 80, 3);
        run_phase(300, 50, 30, 6);
        run_phase(200, 90, 90, 10);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
